imem_dmem_arbiter: RTL and testbench

// - Shares one single-port byte memory between instruction fetch (IF) and data load/store (D).
// - The memory is word-wide, little-endian, with 1-cycle registered read latency.
// - Sits between the pipeline's fetch/mem stages and the shared memory macro.
// - Fixed priority D > IF, with a starvation guard that forces an IF grant.
// - Rejects misaligned and out-of-range accesses locally with an error response.

---
 rtl/imem_dmem_arbiter.sv | 104 ++++++++++
 tb/tb_imem_dmem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: D-over-IF arbiter for one shared word memory, with an IF starvation guard and local error responses.
// Optional perf counters (perf_conflicts, perf_if_stall, perf_starve) are built when MEM_ARB_PERF_EN is defined.
module imem_dmem_arbiter #(
    parameter int unsigned DEPTH_BYTES  = 4096,
    parameter int unsigned STARVE_LIMIT = 4
`ifdef MEM_ARB_PERF_EN
    ,
    parameter int unsigned CNT_W        = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_conflicts,
    output logic [CNT_W-1:0] perf_if_stall,
    output logic [CNT_W-1:0] perf_starve
`endif
);
    localparam int unsigned WC_W = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(STARVE_LIMIT);
    localparam logic [31:0] LAST = 32'(DEPTH_BYTES - 4);

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

    owner_t owner_q, owner_d;
    logic err_q, err_d, we_q, we_d;
    logic [WC_W-1:0] wait_cnt;
    logic guard, good;
    logic [31:0] addr;

    assign guard = STARVE_LIMIT != 0 && wait_cnt == WC_MAX;

    always_comb begin
        d_gnt = !rst && d_req && !(guard && if_req);
        if_gnt = !rst && if_req && !d_gnt;
        addr = d_gnt ? d_addr : if_addr;
        err_d = addr[1:0] != 2'b00 || addr > LAST;
        good = (d_gnt || if_gnt) && !err_d;
        we_d = d_gnt && d_we;
        owner_d = d_gnt ? OWN_D : if_gnt ? OWN_IF : OWN_NONE;
        mem_en = good;
        mem_we = good && we_d;
        mem_addr = addr;
        mem_wdata = d_wdata;
        mem_wstrb = mem_we ? d_wstrb : 4'b0000;
        // responses are suppressed while rst is high so a pending one is dropped immediately
        if_rvalid = !rst && owner_q == OWN_IF;
        d_rvalid = !rst && owner_q == OWN_D;
        if_err = if_rvalid && err_q;
        d_err = d_rvalid && err_q;
        if_rdata = if_rvalid && !err_q ? mem_rdata : 32'h0;
        d_rdata = d_rvalid && !err_q && !we_q ? mem_rdata : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            err_q <= 1'b0;
            we_q <= 1'b0;
            wait_cnt <= '0;
        end else begin
            owner_q <= owner_d;
            err_q <= err_d;
            we_q <= we_d;
            wait_cnt <= (!if_req || if_gnt) ? '0 : wait_cnt == WC_MAX ? wait_cnt : wait_cnt + 1'b1;
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflicts <= '0;
            perf_if_stall <= '0;
            perf_starve <= '0;
        end else begin
            perf_conflicts <= perf_conflicts + CNT_W'(if_req && d_req);
            perf_if_stall <= perf_if_stall + CNT_W'(if_req && !if_gnt);
            perf_starve <= perf_starve + CNT_W'(guard && if_req && d_req);
        end
    end
`endif
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: vector table, directed corner sequences and random traffic against a reference model.
module tb_imem_dmem_arbiter;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  mem_wstrb;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_conflicts, perf_if_stall, perf_starve;
`endif

    always #5 clk = ~clk;

    imem_dmem_arbiter #(.DEPTH_BYTES(4096), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
        , .perf_conflicts(perf_conflicts), .perf_if_stall(perf_if_stall), .perf_starve(perf_starve)
`endif
    );

    // physical memory driven by the DUT's mem_* port; returns junk when not read
    logic [31:0] pmem [1024];
    always @(posedge clk) begin
        if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) pmem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= (mem_en && !mem_we) ? pmem[mem_addr[11:2]] : $urandom;
    end

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    endtask

    // reference model: memory image, starvation count and the single pending response
    logic [31:0] rmem [1024];
    int          m_wait = 0;
    int          p_owner = 0;
    bit          p_err = 0;
    logic [31:0] p_data = '0;

    task automatic model_step();
        bit g, dg, ig, e, ok;
        logic [31:0] a;
        g = m_wait == SL && if_req;
        dg = !rst && d_req && !g;
        ig = !rst && if_req && !dg;
        a = dg ? d_addr : if_addr;
        e = a % 4 != 0 || a > 32'd4092;
        ok = (dg || ig) && !e;
        chk("m_d_gnt", d_gnt, dg);
        chk("m_if_gnt", if_gnt, ig);
        chk("m_mem_en", mem_en, ok);
        if (ok) begin
            chk("m_mem_addr", mem_addr, a);
            chk("m_mem_we", mem_we, dg && d_we);
            if (dg && d_we) begin
                chk("m_mem_wstrb", mem_wstrb, d_wstrb);
                chk("m_mem_wdata", mem_wdata, d_wdata);
            end
        end else chk("m_mem_we_idle", mem_we, 0);
        chk("m_if_rvalid", if_rvalid, !rst && p_owner == 1);
        chk("m_if_err", if_err, !rst && p_owner == 1 && p_err);
        chk("m_if_rdata", if_rdata, (!rst && p_owner == 1) ? p_data : 32'h0);
        chk("m_d_rvalid", d_rvalid, !rst && p_owner == 2);
        chk("m_d_err", d_err, !rst && p_owner == 2 && p_err);
        chk("m_d_rdata", d_rdata, (!rst && p_owner == 2) ? p_data : 32'h0);
        if (rst) begin
            m_wait = 0;
            p_owner = 0;
        end else begin
            m_wait = (if_req && !ig) ? (m_wait < SL ? m_wait + 1 : SL) : 0;
            p_owner = dg ? 2 : ig ? 1 : 0;
            p_err = e;
            p_data = (ok && !(dg && d_we)) ? rmem[a[11:2]] : 32'h0;
            if (ok && dg && d_we)
                for (int b = 0; b < 4; b++)
                    if (d_wstrb[b]) rmem[a[11:2]][8*b +: 8] = d_wdata[8*b +: 8];
        end
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    task automatic cyc(input bit r, input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                       input logic [31:0] da, input logic [31:0] dd, input logic [3:0] ds);
        @(posedge clk);
        #1;
        rst = r; if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_wstrb = ds;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] raddr();
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 15);
        a = 32'($urandom_range(0, 1023)) << 2;
        if (r == 0) a = a | 32'($urandom_range(1, 3));
        else if (r == 1) a = 32'h1000 + (32'($urandom_range(0, 64)) << 2);
        else if (r == 2) a = $urandom;
        return a;
    endfunction

    typedef struct {
        bit ir; logic [31:0] ia; bit dr; bit dw; logic [31:0] da; logic [31:0] dd; logic [3:0] ds;
        bit e_ig; bit e_dg; bit e_en; bit e_err;
    } vec_t;
    vec_t tbl [12];

    initial begin
        bit ig, dg, r, nir, ndr, ndw;
        logic [31:0] nia, nda, ndd;
        logic [3:0] nds;
        tbl[0]  = '{1, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 1, 0};
        tbl[1]  = '{1, 32'hFFC,      0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 1, 0};
        tbl[2]  = '{1, 32'h1000,     0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 0, 1};
        tbl[3]  = '{1, 32'h2,        0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 0, 1};
        tbl[4]  = '{1, 32'hFFFFFFFC, 0, 0, 32'h0,   32'h0,        4'h0, 1, 0, 0, 1};
        tbl[5]  = '{0, 32'h0,        1, 0, 32'hFFC, 32'h0,        4'h0, 0, 1, 1, 0};
        tbl[6]  = '{0, 32'h0,        1, 0, 32'hFFD, 32'h0,        4'h0, 0, 1, 0, 1};
        tbl[7]  = '{0, 32'h0,        1, 1, 32'h100, 32'h12345678, 4'hF, 0, 1, 1, 0};
        tbl[8]  = '{0, 32'h0,        1, 1, 32'h104, 32'hFFFFFFFF, 4'h0, 0, 1, 1, 0};
        tbl[9]  = '{1, 32'h40,       1, 0, 32'h44,  32'h0,        4'h0, 0, 1, 1, 0};
        tbl[10] = '{1, 32'h40,       1, 1, 32'h46,  32'h1,        4'hF, 0, 1, 0, 1};
        tbl[11] = '{0, 32'h0,        0, 0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0};
        for (int i = 0; i < 1024; i++) begin
            pmem[i] = 32'hC0DE0000 | 32'(i);
            rmem[i] = 32'hC0DE0000 | 32'(i);
        end
        pmem[8] = 32'h11223344;
        rmem[8] = 32'h11223344;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        chk("reset_if_rvalid", if_rvalid, 0);
        chk("reset_d_rvalid", d_rvalid, 0);
        chk("reset_mem_en", mem_en, 0);

        foreach (tbl[i]) begin
            cyc(0, tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd, tbl[i].ds);
            chk($sformatf("tbl%0d_if_gnt", i), if_gnt, tbl[i].e_ig);
            chk($sformatf("tbl%0d_d_gnt", i), d_gnt, tbl[i].e_dg);
            chk($sformatf("tbl%0d_mem_en", i), mem_en, tbl[i].e_en);
            idle();
            chk($sformatf("tbl%0d_if_rvalid", i), if_rvalid, tbl[i].e_ig);
            chk($sformatf("tbl%0d_d_rvalid", i), d_rvalid, tbl[i].e_dg);
            chk($sformatf("tbl%0d_err", i), if_err | d_err, tbl[i].e_err);
        end

        cyc(0, 1, 32'h10, 0, 0, 0, 0, 0);
        chk("if_seq_gnt0", if_gnt, 1);
        cyc(0, 1, 32'h14, 0, 0, 0, 0, 0);
        chk("if_seq_gnt1", if_gnt, 1);
        chk("if_seq_rdata0", if_rdata, 32'hC0DE0004);
        cyc(0, 1, 32'h18, 0, 0, 0, 0, 0);
        chk("if_seq_gnt2", if_gnt, 1);
        chk("if_seq_rdata1", if_rdata, 32'hC0DE0005);
        idle();
        chk("if_seq_rdata2", if_rdata, 32'hC0DE0006);
        chk("if_seq_err", if_err, 0);

        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 32'h40, 1, 0, 32'h44, 0, 0);
            chk($sformatf("starve_d_gnt%0d", i), d_gnt, i % 5 != 4);
            chk($sformatf("starve_if_gnt%0d", i), if_gnt, i % 5 == 4);
        end
        idle();
`ifdef MEM_ARB_PERF_EN
        chk("perf_conflicts", perf_conflicts, 10);
        chk("perf_starve", perf_starve, 2);
        chk("perf_if_stall", perf_if_stall, 8);
`endif

        cyc(0, 0, 0, 1, 1, 32'h20, 32'hDEADBEEF, 4'b0011);
        chk("wr_mem_wstrb", mem_wstrb, 4'b0011);
        cyc(0, 0, 0, 1, 0, 32'h20, 0, 0);
        chk("wr_ack_rvalid", d_rvalid, 1);
        chk("wr_ack_rdata", d_rdata, 0);
        idle();
        chk("rd_merged", d_rdata, 32'h1122BEEF);

        cyc(0, 0, 0, 1, 0, 32'h22, 0, 0);
        chk("mis_d_gnt", d_gnt, 1);
        chk("mis_mem_en", mem_en, 0);
        idle();
        chk("mis_d_rvalid", d_rvalid, 1);
        chk("mis_d_err", d_err, 1);
        chk("mis_d_rdata", d_rdata, 0);

        cyc(0, 1, 32'h1000, 0, 0, 0, 0, 0);
        chk("oor_mem_en", mem_en, 0);
        idle();
        chk("oor_if_err", if_err, 1);

        cyc(0, 0, 0, 1, 1, 32'h30, 32'h55555555, 4'b0000);
        chk("zstrb_mem_en", mem_en, 1);
        idle();
        chk("zstrb_ack", d_rvalid, 1);

        cyc(0, 1, 32'h10, 0, 0, 0, 0, 0);
        chk("rst_fetch_gnt", if_gnt, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_drop_rvalid", if_rvalid, 0);
        idle();
        chk("rst_after_if_rvalid", if_rvalid, 0);
        chk("rst_after_rdata", if_rdata | d_rdata, 0);
        chk("rst_after_err", if_err | d_err, 0);
        chk("rst_after_mem_en", mem_en, 0);

        for (int k = 0; k < 400; k++) begin
            ig = if_gnt;
            dg = d_gnt;
            r = $urandom_range(0, 39) == 0;
            nir = (if_req && !ig) ? 1'b1 : 1'($urandom_range(0, 1));
            nia = (if_req && !ig) ? if_addr : raddr();
            if (d_req && !dg) begin
                ndr = 1; ndw = d_we; nda = d_addr; ndd = d_wdata; nds = d_wstrb;
            end else begin
                ndr = 1'($urandom_range(0, 1)); ndw = 1'($urandom_range(0, 1));
                nda = raddr(); ndd = $urandom; nds = 4'($urandom_range(0, 15));
            end
            cyc(r, nir, nia, ndr, ndw, nda, ndd, nds);
        end
        idle();
        idle();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
